// File: rtl/ps_line_fifo_if.sv
// Bundle of the capture-side write port, filter-side read port and the
// status flags of the line FIFO. The FIFO binds to the slave modport, the
// producer/consumer (or a bench) to the master modport.
//
// Handshake semantics: i_wr and i_rd are single-cycle strobes sampled on the
// rising clock edge. A write is taken when i_wr=1 and o_full=0 before the
// edge; a pop is taken when i_rd=1 and o_empty=0 before the edge. Strobes
// against full/empty are dropped and recorded in the sticky flags.
interface ps_line_fifo_if #(
    parameter int DATA_W = 12
);
    logic              i_wr;
    logic [DATA_W-1:0] i_wdata;
    logic              o_full;
    logic              i_rd;
    logic [DATA_W-1:0] o_rdata;
    logic              o_empty;
    logic [9:0]        o_rfill;
    logic              o_line_ready;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output i_wr, i_wdata, i_rd,
        input  o_full, o_rdata, o_empty, o_rfill, o_line_ready, o_overflow, o_underflow
    );

    modport slave (
        input  i_wr, i_wdata, i_rd,
        output o_full, o_rdata, o_empty, o_rfill, o_line_ready, o_overflow, o_underflow
    );
endinterface

// File: rtl/ps_line_fifo.sv
// Single-clock line buffer between pixel capture and the filter pipeline.
// 1024-entry RAM with a registered read port, followed by a one-word output
// prefetch register so the head word is presented first-word-fall-through.
// The RAM read register and the prefetch register form a two-deep pipeline
// that is refilled every cycle, giving one pop per cycle with no bubbles.
module ps_line_fifo #(
    parameter int          DATA_W   = 12,
    parameter int unsigned LINE_LEN = 640
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_flush,
    ps_line_fifo_if.slave  bus
);
    localparam int          AW       = 10;
    localparam logic [AW-1:0] FILL_MAX = 10'd1023;

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];

    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW-1:0]     rfill;
    logic [AW-1:0]     ram_avail;
    logic [DATA_W-1:0] ram_q;
    logic              ram_v;
    logic [DATA_W-1:0] out_q;
    logic              out_v;
    logic              overflow;
    logic              underflow;

    logic full;
    logic wr_ok;
    logic pop;
    logic out_load;
    logic rd_en;

    // Accept/refill decisions from the registered state of this cycle.
    always_comb begin
        full      = (rfill == FILL_MAX);
        wr_ok     = bus.i_wr & ~full;
        pop       = bus.i_rd & out_v;
        // Prefetch takes the RAM read word whenever it is empty or being popped.
        out_load  = ram_v & (~out_v | pop);
        // Words written to RAM but not yet read out; never exceeds 1023, so
        // the 10-bit pointer difference is unambiguous.
        ram_avail = wptr - rptr;
        // Issue a RAM read whenever the read register is free or draining.
        rd_en     = (ram_avail != '0) & (~ram_v | out_load);
    end

    // RAM array with registered read port; write and read addresses never
    // collide because a read is only issued for an already-written word.
    always_ff @(posedge i_clk) begin
        if (wr_ok && i_rstn && !i_flush) begin
            mem[wptr] <= bus.i_wdata;
        end
        if (rd_en) begin
            ram_q <= mem[rptr];
        end
    end

    // Pointers, occupancy, pipeline valids and sticky flags; reset and flush
    // both discard everything in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_flush) begin
            wptr      <= '0;
            rptr      <= '0;
            rfill     <= '0;
            ram_v     <= 1'b0;
            out_v     <= 1'b0;
            out_q     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 10'd1;
            end
            if (rd_en) begin
                rptr <= rptr + 10'd1;
            end

            case ({wr_ok, pop})
                2'b10:   rfill <= rfill + 10'd1;
                2'b01:   rfill <= rfill - 10'd1;
                default: rfill <= rfill;
            endcase

            if (rd_en) begin
                ram_v <= 1'b1;
            end else if (out_load) begin
                ram_v <= 1'b0;
            end

            if (out_load) begin
                out_q <= ram_q;
                out_v <= 1'b1;
            end else if (pop) begin
                out_v <= 1'b0;
            end

            if (bus.i_wr && full) begin
                overflow <= 1'b1;
            end
            if (bus.i_rd && !out_v) begin
                underflow <= 1'b1;
            end
        end
    end

    assign bus.o_full       = full;
    assign bus.o_rdata      = out_q;
    assign bus.o_empty      = ~out_v;
    assign bus.o_rfill      = rfill;
    assign bus.o_line_ready = (32'(rfill) >= LINE_LEN);
    assign bus.o_overflow   = overflow;
    assign bus.o_underflow  = underflow;
endmodule

// File: tb/tb_ps_line_fifo.sv
// Self-checking bench for ps_line_fifo with a queue-based reference model.
// The model holds accepted words with the edge number at which each was
// written; the head word is visible two edges after its write.
module tb_ps_line_fifo;
    localparam int W   = 12;
    localparam int LL  = 640;
    localparam int CAP = 1023;

    logic clk;
    logic rstn;
    logic flush;

    ps_line_fifo_if #(.DATA_W(W)) bus();

    ps_line_fifo #(.DATA_W(W), .LINE_LEN(LL)) dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_flush (flush),
        .bus     (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int           wtime_q[$];
    bit           m_ovf;
    bit           m_unf;

    function automatic bit model_empty();
        return (exp_q.size() == 0) || (wtime_q[0] > cyc - 2);
    endfunction

    // One clock: drive strobes, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit wr, input logic [W-1:0] wd, input bit rd, input bit fl,
                        output bit wr_acc, output bit popped,
                        output logic [W-1:0] exp_w, output logic [W-1:0] act_w);
        bit m_empty;
        bit m_full;
        m_empty = model_empty();
        m_full  = (exp_q.size() == CAP);
        bus.i_wr    = wr;
        bus.i_wdata = wd;
        bus.i_rd    = rd;
        flush       = fl;
        wr_acc = wr && !m_full && !fl;
        popped = rd && !m_empty && !fl;
        exp_w  = m_empty ? '0 : exp_q[0];
        act_w  = bus.o_rdata;
        @(posedge clk);
        cyc++;
        if (fl) begin
            exp_q.delete();
            wtime_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (popped) begin
                void'(exp_q.pop_front());
                void'(wtime_q.pop_front());
            end
            if (wr_acc) begin
                exp_q.push_back(wd);
                wtime_q.push_back(cyc);
            end
            if (wr && m_full) m_ovf = 1'b1;
            if (rd && m_empty) m_unf = 1'b1;
        end
        #1;
        bus.i_wr = 1'b0;
        bus.i_rd = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        bit a, p;
        logic [W-1:0] e, v;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, a, p, e, v);
    endtask

    task automatic do_reset(input int n);
        rstn        = 1'b0;
        bus.i_wr    = 1'b1;
        bus.i_wdata = W'($urandom);
        bus.i_rd    = 1'b1;
        flush       = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
        end
        exp_q.delete();
        wtime_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        rstn     = 1'b1;
        bus.i_wr = 1'b0;
        bus.i_rd = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.o_empty); end
        checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.o_full); end
        checks++; if (bus.o_rfill !== 10'd0) begin errors++; $display("FAIL reset_rfill got=%0d exp=0", bus.o_rfill); end
        checks++; if (bus.o_line_ready !== 1'b0) begin errors++; $display("FAIL reset_line_ready got=%b exp=0", bus.o_line_ready); end
        checks++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", bus.o_overflow, bus.o_underflow); end
        checks++; if (bus.o_rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.o_rdata); end
    endtask

    task automatic test_single();
        bit a, p;
        logic [W-1:0] e, v;
        step(1'b1, 12'hABC, 1'b0, 1'b0, a, p, e, v);
        checks++; if (bus.o_rfill !== 10'd1) begin errors++; $display("FAIL single_rfill_k got=%0d exp=1", bus.o_rfill); end
        checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL single_empty_k got=%b exp=1", bus.o_empty); end
        idle(1);
        checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL single_empty_k1 got=%b exp=1", bus.o_empty); end
        idle(1);
        checks++; if (bus.o_empty !== 1'b0 || bus.o_rdata !== 12'hABC) begin errors++; $display("FAIL single_visible_k2 empty=%b rdata=%h exp empty=0 rdata=abc", bus.o_empty, bus.o_rdata); end
        idle(2);
        checks++; if (bus.o_rdata !== 12'hABC) begin errors++; $display("FAIL single_hold got=%h exp=abc", bus.o_rdata); end
        step(1'b0, '0, 1'b1, 1'b0, a, p, e, v);
        checks++; if (bus.o_empty !== 1'b1 || bus.o_rfill !== 10'd0) begin errors++; $display("FAIL single_pop empty=%b rfill=%0d exp 1/0", bus.o_empty, bus.o_rfill); end
    endtask

    task automatic test_line();
        bit a, p;
        logic [W-1:0] e, v;
        for (int i = 0; i < LL; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b0, a, p, e, v);
            if (i == LL - 2) begin
                checks++; if (bus.o_line_ready !== 1'b0) begin errors++; $display("FAIL line_ready_early got=%b exp=0", bus.o_line_ready); end
            end
        end
        checks++; if (bus.o_line_ready !== 1'b1) begin errors++; $display("FAIL line_ready_640 got=%b exp=1", bus.o_line_ready); end
        for (int i = 0; i < LL; i++) begin
            checks++; if (bus.o_empty !== 1'b0) begin errors++; $display("FAIL line_bubble idx=%0d empty=%b exp=0", i, bus.o_empty); end
            step(1'b0, '0, 1'b1, 1'b0, a, p, e, v);
            checks++; if (v !== W'(i)) begin errors++; $display("FAIL line_data idx=%0d got=%h exp=%h", i, v, W'(i)); end
        end
        checks++; if (bus.o_empty !== 1'b1 || bus.o_rfill !== 10'd0 || bus.o_line_ready !== 1'b0) begin errors++; $display("FAIL line_drained empty=%b rfill=%0d lr=%b", bus.o_empty, bus.o_rfill, bus.o_line_ready); end
    endtask

    task automatic test_full();
        bit a, p;
        logic [W-1:0] e, v;
        for (int i = 0; i < CAP; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, a, p, e, v);
        checks++; if (bus.o_full !== 1'b1 || bus.o_rfill !== 10'd1023) begin errors++; $display("FAIL full_set full=%b rfill=%0d exp 1/1023", bus.o_full, bus.o_rfill); end
        step(1'b1, W'($urandom), 1'b0, 1'b0, a, p, e, v);
        checks++; if (bus.o_rfill !== 10'd1023 || bus.o_overflow !== 1'b1) begin errors++; $display("FAIL full_drop rfill=%0d ovf=%b exp 1023/1", bus.o_rfill, bus.o_overflow); end
        // write and pop together while full: write dropped, pop taken
        step(1'b1, W'($urandom), 1'b1, 1'b0, a, p, e, v);
        checks++; if (v !== e) begin errors++; $display("FAIL full_wrpop_data got=%h exp=%h", v, e); end
        checks++; if (bus.o_rfill !== 10'd1022 || bus.o_full !== 1'b0) begin errors++; $display("FAIL full_wrpop_rfill rfill=%0d full=%b exp 1022/0", bus.o_rfill, bus.o_full); end
        for (int i = 0; i < 1100 && exp_q.size() > 0; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, a, p, e, v);
            checks++; if (!p || v !== e) begin errors++; $display("FAIL full_drain idx=%0d got=%h exp=%h popped=%b", i, v, e, p); end
        end
        checks++; if (bus.o_empty !== 1'b1 || bus.o_rfill !== 10'd0 || bus.o_overflow !== m_ovf) begin errors++; $display("FAIL full_after_drain empty=%b rfill=%0d ovf=%b exp 1/0/%b", bus.o_empty, bus.o_rfill, bus.o_overflow, m_ovf); end
        step(1'b0, '0, 1'b0, 1'b1, a, p, e, v);
    endtask

    task automatic test_underflow();
        bit a, p;
        logic [W-1:0] e, v;
        step(1'b0, '0, 1'b1, 1'b0, a, p, e, v);
        checks++; if (bus.o_underflow !== 1'b1 || bus.o_rfill !== 10'd0 || bus.o_empty !== 1'b1) begin errors++; $display("FAIL underflow unf=%b rfill=%0d empty=%b exp 1/0/1", bus.o_underflow, bus.o_rfill, bus.o_empty); end
        idle(3);
        checks++; if (bus.o_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got=%b exp=1", bus.o_underflow); end
    endtask

    task automatic test_flush();
        bit a, p;
        logic [W-1:0] e, v;
        for (int i = 0; i < 500; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, a, p, e, v);
        checks++; if (bus.o_rfill !== 10'd500) begin errors++; $display("FAIL flush_fill got=%0d exp=500", bus.o_rfill); end
        step(1'b1, W'($urandom), 1'b1, 1'b1, a, p, e, v);
        checks++; if (bus.o_rfill !== 10'd0 || bus.o_empty !== 1'b1 || bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin errors++; $display("FAIL flush_clear rfill=%0d empty=%b ovf=%b unf=%b", bus.o_rfill, bus.o_empty, bus.o_overflow, bus.o_underflow); end
        step(1'b1, 12'h123, 1'b0, 1'b0, a, p, e, v);
        idle(2);
        checks++; if (bus.o_empty !== 1'b0 || bus.o_rdata !== 12'h123 || bus.o_rfill !== 10'd1) begin errors++; $display("FAIL flush_then_write empty=%b rdata=%h rfill=%0d exp 0/123/1", bus.o_empty, bus.o_rdata, bus.o_rfill); end
        step(1'b0, '0, 1'b0, 1'b1, a, p, e, v);
    endtask

    task automatic test_stream();
        bit a, p, wr, rd;
        logic [W-1:0] e, v;
        int written = 0;
        int budget  = 0;
        while ((written < 3000 || exp_q.size() > 0) && budget < 20000) begin
            wr = (written < 3000) && ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) != 0);
            step(wr, W'($urandom), rd, 1'b0, a, p, e, v);
            budget++;
            if (a) written++;
            if (p) begin
                checks++; if (v !== e) begin errors++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, v, e); end
            end
            checks++; if (bus.o_rfill !== 10'(exp_q.size()) || bus.o_empty !== model_empty()) begin errors++; $display("FAIL stream_state cyc=%0d rfill=%0d exp=%0d empty=%b exp=%b", cyc, bus.o_rfill, exp_q.size(), bus.o_empty, model_empty()); end
        end
        checks++; if (budget >= 20000) begin errors++; $display("FAIL stream_timeout written=%0d left=%0d", written, exp_q.size()); end
        checks++; if (bus.o_underflow !== m_unf || bus.o_overflow !== m_ovf) begin errors++; $display("FAIL stream_flags unf=%b exp=%b ovf=%b exp=%b", bus.o_underflow, m_unf, bus.o_overflow, m_ovf); end
    endtask

    task automatic test_reset_midstream();
        bit a, p;
        logic [W-1:0] e, v;
        for (int i = 0; i < 50; i++) step(1'b1, W'($urandom), ($urandom_range(0, 1) == 1), 1'b0, a, p, e, v);
        do_reset(1);
        checks++; if (bus.o_rfill !== 10'd0 || bus.o_empty !== 1'b1 || bus.o_rdata !== '0) begin errors++; $display("FAIL midreset_clear rfill=%0d empty=%b rdata=%h", bus.o_rfill, bus.o_empty, bus.o_rdata); end
        step(1'b1, 12'h5A5, 1'b0, 1'b0, a, p, e, v);
        idle(1);
        checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL midreset_early got=%b exp=1", bus.o_empty); end
        idle(1);
        checks++; if (bus.o_empty !== 1'b0 || bus.o_rdata !== 12'h5A5) begin errors++; $display("FAIL midreset_first empty=%b rdata=%h exp 0/5a5", bus.o_empty, bus.o_rdata); end
    endtask

    initial begin
        rstn        = 1'b0;
        flush       = 1'b0;
        bus.i_wr    = 1'b0;
        bus.i_wdata = '0;
        bus.i_rd    = 1'b0;
        #2;
        test_reset();
        test_single();
        test_line();
        test_full();
        test_underflow();
        test_flush();
        test_stream();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
